intersection_scheduler: RTL and testbench
=========================================

Name: intersection_scheduler

Overview:
- Two-approach (NS/EW) phase scheduler for the traffic controller.
- Sequences green → yellow → all-red for each approach in turn and times every phase with a 1 Hz tick.
- Latches pedestrian requests, shortens the opposing green to serve them, and handles emergency-vehicle preemption.
- Sits between the clock divider (source of `tick`) and the lighting/display logic. It replaces the single-approach sequencing when the design is extended to a full intersection.

Parameters:
TW, 5, timer width in bits
GREEN_TIME, 20, green phase length in ticks
YELLOW_TIME, 3, yellow phase length in ticks
ALLRED_TIME, 2, all-red clearance length in ticks
SHORT_TIME, 5, green remaining-time cap applied when the opposing pedestrian request is pending

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
tick  in  1  one-clk-wide timing enable, 1 Hz
ped_req_ns  in  1  pedestrian push-button for crossing served with NS green; pulse or level
ped_req_ew  in  1  pedestrian push-button for crossing served with EW green
emerg_req  in  1  emergency preemption request, level
emerg_dir  in  1  approach to serve under emergency: 0 = NS, 1 = EW
light_ns  out  3  {red,yellow,green}, one-hot
light_ew  out  3  {red,yellow,green}, one-hot
walk_ns  out  1  walk indication for NS crossing
walk_ew  out  1  walk indication for EW crossing
remaining_time  out  TW  ticks left in current phase
phase  out  3  state code, for debug/display

Behaviour:
- FSM states and `phase` codes: ALL_RED=0, NS_GREEN=1, NS_YELLOW=2, EW_GREEN=3, EW_YELLOW=4. Codes 5-7 are illegal; any illegal state goes to ALL_RED on the next clk.
- Internal `last_dir` register records the most recently served green (0 = NS, 1 = EW).
- All outputs are registered.
- Reset values:
  - state = ALL_RED, remaining_time = ALLRED_TIME, last_dir = 1 (so NS is served first).
  - light_ns = light_ew = 3'b100.
  - walk_ns = walk_ew = 0; pedestrian latches cleared.
- Lights: the green or yellow of one approach forces the other approach to 3'b100. ALL_RED drives 3'b100 on both. Both approaches are never non-red simultaneously.
- Timer behaviour:
  - On phase entry, remaining_time is loaded with that phase's duration.
  - Each tick decrements it.
  - A tick with remaining_time == 1 ends the phase and loads the next phase's duration in the same clk. Each phase therefore lasts exactly its duration in ticks.
  - Durations are 1..2^TW-1.
- Normal sequence: NS_GREEN → NS_YELLOW → ALL_RED → EW_GREEN → EW_YELLOW → ALL_RED → NS_GREEN ...
- ALL_RED exit:
  - If emerg_req, go to green of emerg_dir.
  - Otherwise go to green of !last_dir.
  - Entering a green updates last_dir.
- Pedestrian latches:
  - ped_req_x sets pend_x on any clk; pend_x is sticky.
  - pend_x clears on the clk the x green is entered. walk_x = 1 for that whole green and 0 otherwise.
  - A request arriving during its own green leaves pend_x set for the next x green.
- Green truncation: in a green, if the opposing pend is set and remaining_time > SHORT_TIME, remaining_time is forced to SHORT_TIME on the next tick instead of decrementing. At most one truncation is applied per green.
- Emergency preemption:
  - Checked every clk, independent of tick.
  - In the green of the approach not equal to emerg_dir: go to that approach's yellow next clk, load YELLOW_TIME. A tick in that same clk is ignored.
  - In the green of emerg_dir: remaining_time freezes (ticks ignored) and truncation is suppressed while emerg_req = 1. Countdown resumes from the held value on deassert.
  - Yellow and ALL_RED are never cut short.
  - emerg_dir changing mid-emergency is re-evaluated every clk.
- Priority in a single clk: reset > illegal-state recovery > emergency > phase end > truncation > decrement.
- Reset mid-phase returns immediately (asynchronously) to the reset values. Pedestrian requests pending at reset are lost.

Test Plan:
- Reset, then tick every 4 clks with no requests → ALL_RED 2 ticks, NS_GREEN 20, NS_YELLOW 3, ALL_RED 2, EW_GREEN 20; remaining_time is 20 on NS_GREEN entry and 1 on its last tick; full cycle = 50 ticks.
- ped_req_ew pulsed when NS_GREEN remaining_time = 15 → next tick remaining_time = 5; NS_GREEN ends 5 ticks later; walk_ew = 1 for all 20 ticks of EW_GREEN; pend_ew clears on entry.
- emerg_req = 1 with emerg_dir = 1 during NS_GREEN (remaining_time = 12) → next clk NS_YELLOW, remaining_time = 3; then ALL_RED 2; then EW_GREEN frozen at 20 while emerg_req is held 30 ticks; after release it counts down from 20.
- emerg_req and tick in the same clk during EW_GREEN with emerg_dir = 0 → EW_YELLOW with remaining_time = 3, not 2.
- ped_req_ns during NS_GREEN → walk_ns stays 0 for this green; pend_ns stays set; walk_ns = 1 on the following NS_GREEN.
- reset asserted mid-EW_YELLOW with pend_ns set → same clk: light_ns = light_ew = 100, remaining_time = 2, phase = 0; walk_ns = 0 on the next NS_GREEN.

Source files
------------

// File: rtl/intersection_scheduler_if.sv
// Signal bundle between the intersection scheduler and its surroundings.
// There is no valid/ready handshake: tick is a one-clk enable and the requests are sampled every clk.
interface intersection_scheduler_if #(
  parameter int TW = 5
);
  logic          tick;
  logic          ped_req_ns;
  logic          ped_req_ew;
  logic          emerg_req;
  logic          emerg_dir;
  logic [2:0]    light_ns;
  logic [2:0]    light_ew;
  logic          walk_ns;
  logic          walk_ew;
  logic [TW-1:0] remaining_time;
  logic [2:0]    phase;

  modport master (
    output tick, ped_req_ns, ped_req_ew, emerg_req, emerg_dir,
    input  light_ns, light_ew, walk_ns, walk_ew, remaining_time, phase
  );

  modport slave (
    input  tick, ped_req_ns, ped_req_ew, emerg_req, emerg_dir,
    output light_ns, light_ew, walk_ns, walk_ew, remaining_time, phase
  );
endinterface

// File: rtl/intersection_scheduler.sv
// Two-approach (NS/EW) phase scheduler: green/yellow/all-red sequencing timed by a 1 Hz tick,
// with pedestrian-driven green truncation and emergency preemption. The FSM state is visible on phase.
module intersection_scheduler #(
  parameter int TW          = 5,
  parameter int GREEN_TIME  = 20,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2,
  parameter int SHORT_TIME  = 5
) (
  input logic                    clk,
  input logic                    reset,
  intersection_scheduler_if.slave bus
);
  localparam logic [2:0] ALL_RED   = 3'd0;
  localparam logic [2:0] NS_GREEN  = 3'd1;
  localparam logic [2:0] NS_YELLOW = 3'd2;
  localparam logic [2:0] EW_GREEN  = 3'd3;
  localparam logic [2:0] EW_YELLOW = 3'd4;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [TW-1:0] ONE      = TW'(1);
  localparam logic [TW-1:0] GREEN_T  = TW'(GREEN_TIME);
  localparam logic [TW-1:0] YELLOW_T = TW'(YELLOW_TIME);
  localparam logic [TW-1:0] ALLRED_T = TW'(ALLRED_TIME);
  localparam logic [TW-1:0] SHORT_T  = TW'(SHORT_TIME);

  logic [2:0]    state, state_d;
  logic [TW-1:0] rem, rem_d;
  logic          last_dir, last_d;
  logic          pend_ns, pend_ns_d, pend_ew, pend_ew_d;
  logic          trunc_done, trunc_d;
  logic          walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
  logic [2:0]    light_ns_q, light_ns_d, light_ew_q, light_ew_d;
  logic          go_ew, is_ew, opp_pend;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ALL_RED;
      rem        <= ALLRED_T;
      last_dir   <= 1'b1;
      pend_ns    <= 1'b0;
      pend_ew    <= 1'b0;
      trunc_done <= 1'b0;
      walk_ns_q  <= 1'b0;
      walk_ew_q  <= 1'b0;
      light_ns_q <= RED;
      light_ew_q <= RED;
    end else begin
      state      <= state_d;
      rem        <= rem_d;
      last_dir   <= last_d;
      pend_ns    <= pend_ns_d;
      pend_ew    <= pend_ew_d;
      trunc_done <= trunc_d;
      walk_ns_q  <= walk_ns_d;
      walk_ew_q  <= walk_ew_d;
      light_ns_q <= light_ns_d;
      light_ew_q <= light_ew_d;
    end
  end

  // Next-state logic; both greens share one branch, is_ew selects the approach
  always_comb begin
    state_d   = state;
    rem_d     = rem;
    last_d    = last_dir;
    pend_ns_d = pend_ns | bus.ped_req_ns;
    pend_ew_d = pend_ew | bus.ped_req_ew;
    trunc_d   = trunc_done;
    walk_ns_d = walk_ns_q;
    walk_ew_d = walk_ew_q;
    go_ew     = 1'b0;
    is_ew     = (state == EW_GREEN);
    opp_pend  = is_ew ? pend_ns : pend_ew;
    case (state)
      ALL_RED: begin
        if (bus.tick) begin
          if (rem == ONE) begin
            go_ew   = bus.emerg_req ? bus.emerg_dir : ~last_dir;
            rem_d   = GREEN_T;
            last_d  = go_ew;
            trunc_d = 1'b0;
            if (go_ew) begin
              state_d   = EW_GREEN;
              walk_ew_d = pend_ew_d;
              pend_ew_d = 1'b0;
            end else begin
              state_d   = NS_GREEN;
              walk_ns_d = pend_ns_d;
              pend_ns_d = 1'b0;
            end
          end else begin
            rem_d = rem - ONE;
          end
        end
      end
      NS_GREEN, EW_GREEN: begin
        if (bus.emerg_req && (bus.emerg_dir != is_ew)) begin
          state_d = is_ew ? EW_YELLOW : NS_YELLOW;
          rem_d   = YELLOW_T;
        end else if (bus.emerg_req) begin
          rem_d = rem;  // served approach holds its green while the emergency lasts
        end else if (bus.tick) begin
          if (rem == ONE) begin
            state_d = is_ew ? EW_YELLOW : NS_YELLOW;
            rem_d   = YELLOW_T;
          end else if (opp_pend && !trunc_done && (rem > SHORT_T)) begin
            rem_d   = SHORT_T;
            trunc_d = 1'b1;
          end else begin
            rem_d = rem - ONE;
          end
        end
      end
      NS_YELLOW, EW_YELLOW: begin
        if (bus.tick) begin
          if (rem == ONE) begin
            state_d = ALL_RED;
            rem_d   = ALLRED_T;
          end else begin
            rem_d = rem - ONE;
          end
        end
      end
      default: begin
        state_d = ALL_RED;
        rem_d   = ALLRED_T;
      end
    endcase
    if (state_d != NS_GREEN) walk_ns_d = 1'b0;
    if (state_d != EW_GREEN) walk_ew_d = 1'b0;
  end

  // Output logic: lights follow the next state so they register alongside it
  always_comb begin
    light_ns_d = RED;
    light_ew_d = RED;
    case (state_d)
      NS_GREEN:  light_ns_d = GRN;
      NS_YELLOW: light_ns_d = YEL;
      EW_GREEN:  light_ew_d = GRN;
      EW_YELLOW: light_ew_d = YEL;
      default: begin
        light_ns_d = RED;
        light_ew_d = RED;
      end
    endcase
  end

  assign bus.light_ns       = light_ns_q;
  assign bus.light_ew       = light_ew_q;
  assign bus.walk_ns        = walk_ns_q;
  assign bus.walk_ew        = walk_ew_q;
  assign bus.remaining_time = rem;
  assign bus.phase          = state;
endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler: normal cycle, pedestrian truncation, walk latching,
// emergency preemption and asynchronous reset, against hand-computed values.
module tb_intersection_scheduler;
  logic clk;
  logic reset;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  intersection_scheduler_if #(.TW(5)) bus ();

  intersection_scheduler #(
    .TW(5), .GREEN_TIME(20), .YELLOW_TIME(3), .ALLRED_TIME(2), .SHORT_TIME(5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One tick pulse, then idle so ticks arrive every 4 clks
  task automatic do_tick();
    @(negedge clk) bus.tick = 1'b1;
    @(negedge clk) bus.tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic pulse_ped(input logic ew);
    @(negedge clk);
    if (ew) bus.ped_req_ew = 1'b1; else bus.ped_req_ns = 1'b1;
    @(negedge clk);
    bus.ped_req_ew = 1'b0;
    bus.ped_req_ns = 1'b0;
  endtask

  task automatic expect_state(input string tag, input int ph, input int rem);
    check({tag, ".phase"}, 32'(bus.phase), 32'(ph));
    check({tag, ".rem"}, 32'(bus.remaining_time), 32'(rem));
  endtask

  initial begin
    reset          = 1'b1;
    bus.tick       = 1'b0;
    bus.ped_req_ns = 1'b0;
    bus.ped_req_ew = 1'b0;
    bus.emerg_req  = 1'b0;
    bus.emerg_dir  = 1'b0;
    repeat (2) @(negedge clk);
    expect_state("reset", 0, 2);
    check("reset.light_ns", 32'(bus.light_ns), 32'(RED));
    check("reset.light_ew", 32'(bus.light_ew), 32'(RED));
    check("reset.walk_ns", 32'(bus.walk_ns), 0);
    check("reset.walk_ew", 32'(bus.walk_ew), 0);
    reset = 1'b0;

    // Normal cycle with no requests
    ticks(1);
    expect_state("ar_t1", 0, 1);
    ticks(1);
    expect_state("ns_entry", 1, 20);
    check("ns_entry.light_ns", 32'(bus.light_ns), 32'(GRN));
    check("ns_entry.light_ew", 32'(bus.light_ew), 32'(RED));
    check("ns_entry.walk_ns", 32'(bus.walk_ns), 0);
    ticks(19);
    expect_state("ns_last", 1, 1);
    ticks(1);
    expect_state("ns_yel", 2, 3);
    check("ns_yel.light_ns", 32'(bus.light_ns), 32'(YEL));
    ticks(3);
    expect_state("ar_mid", 0, 2);
    check("ar_mid.light_ns", 32'(bus.light_ns), 32'(RED));
    ticks(2);
    expect_state("ew_entry", 3, 20);
    check("ew_entry.light_ew", 32'(bus.light_ew), 32'(GRN));
    check("ew_entry.light_ns", 32'(bus.light_ns), 32'(RED));
    ticks(20);
    expect_state("ew_yel", 4, 3);
    check("ew_yel.light_ew", 32'(bus.light_ew), 32'(YEL));
    ticks(5);
    expect_state("ns_cycle2", 1, 20);

    // Pedestrian EW request truncates NS green
    ticks(5);
    expect_state("ns_15", 1, 15);
    pulse_ped(1'b1);
    expect_state("ped_ew_no_tick", 1, 15);
    ticks(1);
    expect_state("trunc", 1, 5);
    ticks(4);
    expect_state("trunc_last", 1, 1);
    ticks(1);
    expect_state("trunc_yel", 2, 3);
    ticks(5);
    expect_state("ew_walk_entry", 3, 20);
    check("ew_walk_entry.walk_ew", 32'(bus.walk_ew), 1);
    ticks(19);
    expect_state("ew_walk_last", 3, 1);
    check("ew_walk_last.walk_ew", 32'(bus.walk_ew), 1);
    ticks(1);
    check("ew_walk_off", 32'(bus.walk_ew), 0);
    ticks(5);

    // Request during own green waits for the next green
    expect_state("ns_own", 1, 20);
    pulse_ped(1'b0);
    check("ns_own.walk_ns", 32'(bus.walk_ns), 0);
    ticks(20);
    check("ns_own_end.walk_ns", 32'(bus.walk_ns), 0);
    ticks(5);
    expect_state("ew_pre_emerg", 3, 20);

    // Emergency and tick in the same clk: tick ignored
    @(negedge clk);
    bus.tick      = 1'b1;
    bus.emerg_req = 1'b1;
    bus.emerg_dir = 1'b0;
    @(negedge clk);
    bus.tick      = 1'b0;
    expect_state("emerg_tick", 4, 3);
    bus.emerg_req = 1'b0;
    ticks(5);
    expect_state("ns_walk_next", 1, 20);
    check("ns_walk_next.walk_ns", 32'(bus.walk_ns), 1);

    // Emergency toward EW preempts NS green
    ticks(8);
    expect_state("ns_12", 1, 12);
    @(negedge clk);
    bus.emerg_req = 1'b1;
    bus.emerg_dir = 1'b1;
    @(negedge clk);
    expect_state("preempt", 2, 3);
    check("preempt.walk_ns", 32'(bus.walk_ns), 0);
    ticks(3);
    expect_state("preempt_ar", 0, 2);
    ticks(2);
    expect_state("emerg_ew", 3, 20);
    ticks(30);
    expect_state("emerg_frozen", 3, 20);
    @(negedge clk) bus.emerg_req = 1'b0;
    ticks(1);
    expect_state("emerg_resume", 3, 19);

    // Async reset mid EW_YELLOW with pend_ns set
    pulse_ped(1'b0);
    ticks(1);
    expect_state("ew_trunc", 3, 5);
    ticks(5);
    ticks(1);
    expect_state("ew_yel2", 4, 2);
    #2 reset = 1'b1;
    #1;
    expect_state("async_rst", 0, 2);
    check("async_rst.light_ns", 32'(bus.light_ns), 32'(RED));
    check("async_rst.light_ew", 32'(bus.light_ew), 32'(RED));
    @(negedge clk) reset = 1'b0;
    ticks(2);
    expect_state("post_rst_ns", 1, 20);
    check("post_rst_ns.walk_ns", 32'(bus.walk_ns), 0);
    check("post_rst_ns.light_ns", 32'(bus.light_ns), 32'(GRN));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
